om_timing_est: RTL and testbench

OM_TIMING_EST -- requirements
Module: om_timing_est

---
 rtl/om_pkg.sv | 23 ++
 rtl/om_mag2.sv | 55 +++++
 rtl/om_timing_est.sv | 112 +++++++++++
 tb/tb_om_timing_est.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/om_pkg.sv
// Shared constants and width helpers for the Oerder-Meyr timing estimator.
package om_pkg;

  // Fixed oversampling ratio and the width of the phase index that selects S0..S3
  localparam int OSR     = 4;
  localparam int PHASE_W = 2;

  // Width of an exact squared magnitude i^2 + q^2
  function automatic int mag_width(input int data_w);
    return 2 * data_w;
  endfunction

  // Width of one phase accumulator summing L magnitudes
  function automatic int acc_width(input int data_w, input int log2_syms);
    return 2 * data_w + log2_syms;
  endfunction

  // Width of the signed accumulator differences Re(Xm) / Im(Xm)
  function automatic int out_width(input int data_w, input int log2_syms);
    return acc_width(data_w, log2_syms) + 1;
  endfunction

endpackage

// File: rtl/om_mag2.sv
// Two-stage squared-magnitude pipeline: squares, then their sum, with a
// travelling valid bit that a flush can kill at any stage.
module om_mag2
  import om_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic signed [DATA_W-1:0]      din_i,
  input  logic signed [DATA_W-1:0]      din_q,
  output logic [mag_width(DATA_W)-1:0]  mag2,
  output logic                          mag2_valid,
  output logic                          stage1_valid
);

  localparam int MAG_W = mag_width(DATA_W);

  logic signed [MAG_W-1:0] prod_i;
  logic signed [MAG_W-1:0] prod_q;
  logic [MAG_W-1:0]        sq_i_reg;
  logic [MAG_W-1:0]        sq_q_reg;
  logic                    v1_reg;
  logic [MAG_W-1:0]        mag_reg;
  logic                    v2_reg;

  // Squares are always non-negative and at most 2^(2*DATA_W-2), so the
  // signed product bits read directly as an unsigned value.
  assign prod_i = din_i * din_i;
  assign prod_q = din_q * din_q;

  // Stage 1 registers the squares, stage 2 their exact sum; flush drops valids
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_i_reg <= '0;
      sq_q_reg <= '0;
      v1_reg   <= 1'b0;
      mag_reg  <= '0;
      v2_reg   <= 1'b0;
    end else begin
      sq_i_reg <= prod_i;
      sq_q_reg <= prod_q;
      mag_reg  <= sq_i_reg + sq_q_reg;
      v1_reg   <= in_valid & ~flush;
      v2_reg   <= v1_reg & ~flush;
    end
  end

  assign mag2         = mag_reg;
  assign mag2_valid   = v2_reg;
  assign stage1_valid = v1_reg;

endmodule

// File: rtl/om_timing_est.sv
// Oerder-Meyr timing estimator front end: accumulates |x|^2 per sample phase
// over 4L samples and emits Xm = (S0 - S2) + j(S3 - S1) per block.
module om_timing_est
  import om_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int LOG2_SYMS = 6
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         clear,
  input  logic                                         din_valid,
  input  logic signed [DATA_W-1:0]                     din_i,
  input  logic signed [DATA_W-1:0]                     din_q,
  output logic signed [out_width(DATA_W, LOG2_SYMS)-1:0] xm_re,
  output logic signed [out_width(DATA_W, LOG2_SYMS)-1:0] xm_im,
  output logic                                         xm_valid,
  output logic                                         busy
);

  localparam int MAG_W = mag_width(DATA_W);
  localparam int ACC_W = acc_width(DATA_W, LOG2_SYMS);
  localparam int OUT_W = out_width(DATA_W, LOG2_SYMS);
  localparam int CNT_W = LOG2_SYMS + PHASE_W;

  logic                    accept;
  logic [MAG_W-1:0]        mag2;
  logic                    mag2_valid;
  logic                    stage1_valid;

  logic [CNT_W-1:0]        cnt_reg;
  logic [CNT_W-1:0]        cnt_next;
  logic [ACC_W-1:0]        acc_reg  [OSR];
  logic [ACC_W-1:0]        acc_next [OSR];
  logic                    last_next;
  logic                    busy_next;
  logic signed [OUT_W-1:0] xm_re_next;
  logic signed [OUT_W-1:0] xm_im_next;
  logic signed [OUT_W-1:0] xm_re_reg;
  logic signed [OUT_W-1:0] xm_im_reg;
  logic                    xm_valid_reg;
  logic                    busy_reg;

  // A sample presented together with clear belongs to no block
  assign accept = din_valid & ~clear;

  om_mag2 #(
    .DATA_W(DATA_W)
  ) u_mag2 (
    .clk         (clk),
    .rst         (rst),
    .flush       (clear),
    .in_valid    (accept),
    .din_i       (din_i),
    .din_q       (din_q),
    .mag2        (mag2),
    .mag2_valid  (mag2_valid),
    .stage1_valid(stage1_valid)
  );

  // The counter sits at the accumulator side: samples leave the pipe in
  // acceptance order and flushes reset both ends together, so its low bits
  // are the phase index of the magnitude arriving now.
  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    if (mag2_valid) begin
      acc_next[cnt_reg[PHASE_W-1:0]] = acc_reg[cnt_reg[PHASE_W-1:0]] + ACC_W'(mag2);
      cnt_next = cnt_reg + 1'b1;
    end
    last_next  = mag2_valid && (cnt_reg == {CNT_W{1'b1}});
    xm_re_next = OUT_W'(acc_next[0]) - OUT_W'(acc_next[2]);
    xm_im_next = OUT_W'(acc_next[3]) - OUT_W'(acc_next[1]);
    // Work is outstanding if a sample arrives now, one sits in stage 1, or
    // the running block still holds accumulated samples after this cycle.
    busy_next  = accept || stage1_valid || (cnt_next != '0);
  end

  // Accumulate, close the block on the final magnitude, and restart at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      for (int p = 0; p < OSR; p++) acc_reg[p] <= '0;
      xm_re_reg    <= '0;
      xm_im_reg    <= '0;
      xm_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else if (clear) begin
      cnt_reg      <= '0;
      for (int p = 0; p < OSR; p++) acc_reg[p] <= '0;
      xm_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      xm_valid_reg <= last_next;
      busy_reg     <= busy_next;
      if (last_next) begin
        for (int p = 0; p < OSR; p++) acc_reg[p] <= '0;
        xm_re_reg <= xm_re_next;
        xm_im_reg <= xm_im_next;
      end else begin
        acc_reg <= acc_next;
      end
    end
  end

  assign xm_re    = xm_re_reg;
  assign xm_im    = xm_im_reg;
  assign xm_valid = xm_valid_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_om_timing_est.sv
// Directed bench for om_timing_est with 16-sample blocks (L = 4).
module tb_om_timing_est;

  localparam int DW = 12;
  localparam int LS = 2;
  localparam int OW = 2 * DW + LS + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clear = 1'b0;
  logic                 din_valid = 1'b0;
  logic signed [DW-1:0] din_i = '0;
  logic signed [DW-1:0] din_q = '0;
  logic signed [OW-1:0] xm_re;
  logic signed [OW-1:0] xm_im;
  logic                 xm_valid;
  logic                 busy;

  om_timing_est #(
    .DATA_W   (DW),
    .LOG2_SYMS(LS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .din_valid(din_valid),
    .din_i    (din_i),
    .din_q    (din_q),
    .xm_re    (xm_re),
    .xm_im    (xm_im),
    .xm_valid (xm_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  // Strobe log, sampled on the falling edge
  int     strobe_cnt = 0;
  longint re_q[$];
  longint im_q[$];
  int     cyc_q[$];
  logic   busy_q[$];

  always @(negedge clk) begin
    if (xm_valid === 1'b1) begin
      strobe_cnt++;
      re_q.push_back(longint'(xm_re));
      im_q.push_back(longint'(xm_im));
      cyc_q.push_back(cyc);
      busy_q.push_back(busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus patterns: 0 all i=100; 1 i=100 on k=0; 2 i=100 on k=1;
  // 3 i=q=-2048 on k=0; 4 i=q=-2048 on every phase
  task automatic pat(input int mode, input int k,
                     output logic signed [DW-1:0] i, output logic signed [DW-1:0] q);
    i = '0;
    q = '0;
    case (mode)
      0: i = 12'sd100;
      1: if (k == 0) i = 12'sd100;
      2: if (k == 1) i = 12'sd100;
      3: if (k == 0) begin i = 12'sh800; q = 12'sh800; end
      4: begin i = 12'sh800; q = 12'sh800; end
      default: ;
    endcase
  endtask

  // Presents nsamp samples with gap idle cycles between them; returns the
  // cycle number during which the last sample was presented.
  task automatic send_block(input int mode, input int gap, input int nsamp, output int last_p);
    last_p = 0;
    for (int n = 0; n < nsamp; n++) begin
      pat(mode, n % 4, din_i, din_q);
      din_valid = 1'b1;
      last_p = cyc;
      tick();
      din_valid = 1'b0;
      din_i = '0;
      din_q = '0;
      if (n < nsamp - 1) repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      din_valid = 1'($urandom_range(0, 1));
      clear     = 1'($urandom_range(0, 1));
      din_i     = DW'($urandom);
      din_q     = DW'($urandom);
      tick();
      vectors++;
      if ({xm_re, xm_im, xm_valid, busy} !== '0) begin
        errors++;
        $display("FAIL reset_outputs c%0d: got re=%0d im=%0d v=%b busy=%b required all 0",
                 c, xm_re, xm_im, xm_valid, busy);
      end
    end
    rst = 1'b0; clear = 1'b0; din_valid = 1'b0; din_i = '0; din_q = '0;
    repeat (4) tick();
    vectors++;
    if (strobe_cnt !== 0 || xm_re !== '0 || xm_im !== '0) begin
      errors++;
      $display("FAIL reset_quiet: got strobes=%0d re=%0d im=%0d required 0 0 0",
               strobe_cnt, xm_re, xm_im);
    end
    $display("reset: %0d strobes, re=%0d im=%0d busy=%b", strobe_cnt, xm_re, xm_im, busy);
  endtask

  task automatic test_blocks();
    int     modes  [5] = '{0, 1, 2, 3, 4};
    longint exp_re [5] = '{0, 40000, 0, 33554432, 0};
    longint exp_im [5] = '{0, 0, -40000, 0, 0};
    int base;
    int p;
    for (int t = 0; t < 5; t++) begin
      base = strobe_cnt;
      send_block(modes[t], 0, 16, p);
      repeat (6) tick();
      vectors++;
      if (strobe_cnt - base !== 1) begin
        errors++;
        $display("FAIL block%0d_strobes: got %0d required 1", modes[t], strobe_cnt - base);
      end else begin
        $display("block mode %0d: re=%0d im=%0d at cycle %0d (last sample %0d)",
                 modes[t], re_q[base], im_q[base], cyc_q[base], p);
        vectors++;
        if (re_q[base] !== exp_re[t] || im_q[base] !== exp_im[t]) begin
          errors++;
          $display("FAIL block%0d_value: got re=%0d im=%0d required re=%0d im=%0d",
                   modes[t], re_q[base], im_q[base], exp_re[t], exp_im[t]);
        end
        vectors++;
        if (cyc_q[base] !== p + 3) begin
          errors++;
          $display("FAIL block%0d_latency: got cycle %0d required %0d", modes[t], cyc_q[base], p + 3);
        end
        vectors++;
        if (busy_q[base] !== 1'b0) begin
          errors++;
          $display("FAIL block%0d_busy_at_strobe: got %b required 0", modes[t], busy_q[base]);
        end
      end
      vectors++;
      if (longint'(xm_re) !== exp_re[t] || longint'(xm_im) !== exp_im[t]) begin
        errors++;
        $display("FAIL block%0d_hold: got re=%0d im=%0d required re=%0d im=%0d",
                 modes[t], xm_re, xm_im, exp_re[t], exp_im[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int p1;
    int p2;
    base = strobe_cnt;
    send_block(1, 2, 16, p1);
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_busy_midflight: got %b required 1", busy);
    end
    send_block(1, 0, 16, p2);
    repeat (6) tick();
    vectors++;
    if (strobe_cnt - base !== 2) begin
      errors++;
      $display("FAIL b2b_strobes: got %0d required 2", strobe_cnt - base);
    end else begin
      for (int b = 0; b < 2; b++) begin
        $display("b2b block %0d: re=%0d im=%0d at cycle %0d busy=%b",
                 b, re_q[base+b], im_q[base+b], cyc_q[base+b], busy_q[base+b]);
        vectors++;
        if (re_q[base+b] !== 40000 || im_q[base+b] !== 0) begin
          errors++;
          $display("FAIL b2b%0d_value: got re=%0d im=%0d required re=40000 im=0",
                   b, re_q[base+b], im_q[base+b]);
        end
        vectors++;
        if (cyc_q[base+b] !== ((b == 0) ? p1 : p2) + 3) begin
          errors++;
          $display("FAIL b2b%0d_latency: got cycle %0d required %0d",
                   b, cyc_q[base+b], ((b == 0) ? p1 : p2) + 3);
        end
        vectors++;
        if (busy_q[base+b] !== ((b == 0) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL b2b%0d_busy: got %b required %b", b, busy_q[base+b], (b == 0) ? 1'b1 : 1'b0);
        end
      end
    end
  endtask

  // Abandon a 10-sample partial block by clear (use_rst=0) or rst (use_rst=1)
  task automatic test_abort(input bit use_rst);
    int  base;
    int  p;
    longint keep_re;
    longint keep_im;
    send_block(2, 0, 16, p);
    repeat (6) tick();
    keep_re = use_rst ? 0 : 0;
    keep_im = use_rst ? 0 : -40000;
    send_block(1, 0, 10, p);
    base = strobe_cnt;
    if (use_rst) rst = 1'b1; else clear = 1'b1;
    din_valid = 1'b1;
    din_i = 12'sd100;
    tick();
    rst = 1'b0; clear = 1'b0; din_valid = 1'b0; din_i = '0;
    vectors++;
    if (longint'(xm_re) !== keep_re || longint'(xm_im) !== keep_im || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort%0d_after: got re=%0d im=%0d busy=%b required re=%0d im=%0d busy=0",
               use_rst, xm_re, xm_im, busy, keep_re, keep_im);
    end
    send_block(1, 0, 16, p);
    vectors++;
    if (longint'(xm_re) !== keep_re || longint'(xm_im) !== keep_im) begin
      errors++;
      $display("FAIL abort%0d_prestrobe: got re=%0d im=%0d required re=%0d im=%0d",
               use_rst, xm_re, xm_im, keep_re, keep_im);
    end
    repeat (6) tick();
    vectors++;
    if (strobe_cnt - base !== 1) begin
      errors++;
      $display("FAIL abort%0d_strobes: got %0d required 1", use_rst, strobe_cnt - base);
    end else begin
      $display("abort via %s: re=%0d im=%0d at cycle %0d (last sample %0d)",
               use_rst ? "rst" : "clear", re_q[base], im_q[base], cyc_q[base], p);
      vectors++;
      if (re_q[base] !== 40000 || im_q[base] !== 0 || cyc_q[base] !== p + 3) begin
        errors++;
        $display("FAIL abort%0d_value: got re=%0d im=%0d cycle=%0d required re=40000 im=0 cycle=%0d",
                 use_rst, re_q[base], im_q[base], cyc_q[base], p + 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_blocks();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
